interboard_link: RTL and testbench
==================================

INTERBOARD_LINK -- requirements
Module: interboard_link

Interface
REQ-001 Parameter DATA_W, default 6, SHALL set the width of every data word on the link and the local ports.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the TX FIFO depth in words; it SHALL be a power of two and at least 2.
REQ-003 Parameter TIMEOUT_CYC, default 1023, SHALL set the cycles to wait for Ack_in before one send attempt is abandoned.
REQ-004 Parameter MAX_RETRY, default 3, SHALL set how many re-sends follow the first timed-out attempt.
REQ-005 clk  in  1  SHALL be the single clock.
REQ-006 rst  in  1  SHALL be the reset; asynchronous, active-low.
REQ-007 tx_valid  in  1  SHALL be the push strobe for tx_data.
REQ-008 tx_data  in  DATA_W  SHALL be the word to send.
REQ-009 tx_ready  out  1  SHALL be high when the FIFO is not full.
REQ-010 fifo_count  out  clog2(FIFO_DEPTH+1)  SHALL be the number of queued words.
REQ-011 tx_done  out  1  SHALL pulse for one cycle when a word is acknowledged.
REQ-012 tx_err  out  1  SHALL pulse for one cycle when a word is dropped after its final retry.
REQ-013 rx_valid  out  1  SHALL pulse for one cycle when a word is received.
REQ-014 rx_data  out  DATA_W  SHALL be the last received word, held until the next receive.
REQ-015 Request_out, Ack_out  out  1 each  SHALL be the outgoing handshake lines.
REQ-016 inter_data_out  out  DATA_W  SHALL be the outgoing data bus.
REQ-017 Request_in, Ack_in  in  1 each  SHALL be the asynchronous incoming handshake lines.
REQ-018 inter_data_in  in  DATA_W  SHALL be the incoming data bus.
REQ-019 link_busy  out  1  SHALL be high whenever the TX FSM is not in IDLE.

Function
REQ-020 Request_in and Ack_in SHALL each pass through a 2-flop synchroniser; all FSM decisions SHALL use only the synchronised copies.
REQ-021 FIFO push SHALL occur when tx_valid and tx_ready are both high; a push while full SHALL be ignored without error.
REQ-022 A push and a pop in the same cycle SHALL both take effect, leaving fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 TX FSM states SHALL be IDLE, SETUP, REQ, REL and GAP.
REQ-024 IDLE: if the FIFO is non-empty, the FSM SHALL drive the FIFO head onto inter_data_out and go to SETUP.
REQ-025 SETUP (one cycle): the FSM SHALL hold the data, set Request_out=1 and go to REQ; data SHALL therefore lead the request by at least 1 cycle.
REQ-026 REQ: when synced Ack_in=1, the FSM SHALL set Request_out=0, pop the head, pulse tx_done and go to REL.
REQ-027 REQ timeout: after TIMEOUT_CYC cycles in REQ without Ack_in, the FSM SHALL set Request_out=0 and go to GAP.
REQ-028 REL: the FSM SHALL wait for synced Ack_in=0, then go to IDLE; inter_data_out SHALL stay stable from SETUP until REL exits.
REQ-029 GAP: the FSM SHALL wait 4 cycles and then apply the retry rule.
REQ-030 Retry rule: if retries < MAX_RETRY, the FSM SHALL increment the retry count and go to SETUP with the same word; otherwise it SHALL pop the word, pulse tx_err, clear the retry count and go to IDLE.
REQ-031 The retry count and timeout counter SHALL clear on every exit from REQ via ack and on every pop.
REQ-032 RX FSM states SHALL be R_IDLE and R_ACK.
REQ-033 R_IDLE: on synced Request_in=1, the FSM SHALL capture inter_data_in into rx_data, pulse rx_valid, set Ack_out=1 and go to R_ACK.
REQ-034 R_ACK: on synced Request_in=0, the FSM SHALL set Ack_out=0 and go to R_IDLE; exactly one rx_valid pulse SHALL occur per request.
REQ-035 The TX and RX FSMs SHALL run independently, so full-duplex operation is allowed.

Reset
REQ-036 While rst=0, all outputs SHALL be 0 except tx_ready=1.
REQ-037 While rst=0, the FIFO SHALL be empty, both FSMs SHALL be in IDLE/R_IDLE, and all counters and synchronisers SHALL be 0.
REQ-038 A reset mid-handshake SHALL drop Request_out and Ack_out asynchronously and discard queued words without pulsing tx_done or tx_err.

Verification
REQ-039 Loopback (Request_out->Request_in, Ack_out->Ack_in, data looped), push 0x2A -> rx_valid once with rx_data=0x2A, tx_done once, link_busy then 0.
REQ-040 Push 5 words with FIFO_DEPTH=4 and the link stalled -> the 5th push is ignored, tx_ready=0 and fifo_count=4; after release, words arrive in order.
REQ-041 Ack_in tied 0 -> 4 Request_out pulses each lasting TIMEOUT_CYC cycles, then one tx_err pulse and fifo_count decrements by 1.
REQ-042 Ack arrives on the 2nd attempt -> exactly 1 tx_done, 0 tx_err, and the same data on both attempts.
REQ-043 Push and pop in the same cycle with fifo_count=2 -> fifo_count stays 2.
REQ-044 Assert rst during REQ with 3 words queued -> Request_out=0 immediately, fifo_count=0 and tx_ready=1.

Source files
------------

// File: rtl/interboard_link.sv
// Inter-board word link: a TX FIFO feeds a four-phase request/ack sender with
// timeout and retry, and an independent RX responder acks incoming requests.
//
// TX FSM
//   state | meaning
//   IDLE  | waiting for a queued word
//   SETUP | head word on the data bus, request raised next edge
//   REQ   | request high, waiting for ack or timeout
//   REL   | word acknowledged, waiting for ack to fall
//   GAP   | request dropped after timeout, 4-cycle pause before retry/drop
//
// RX FSM
//   state  | meaning
//   R_IDLE | waiting for a request
//   R_ACK  | word captured, ack high until request falls
module interboard_link #(
  parameter int DATA_W      = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1023,
  parameter int MAX_RETRY   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tx_valid,
  input  logic [DATA_W-1:0]                tx_data,
  output logic                             tx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             tx_done,
  output logic                             tx_err,
  output logic                             rx_valid,
  output logic [DATA_W-1:0]                rx_data,
  output logic                             Request_out,
  output logic                             Ack_out,
  output logic [DATA_W-1:0]                inter_data_out,
  input  logic                             Request_in,
  input  logic                             Ack_in,
  input  logic [DATA_W-1:0]                inter_data_in,
  output logic                             link_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, SETUP, REQ, REL, GAP} tx_state_t;
  typedef enum logic {R_IDLE, R_ACK} rx_state_t;

  logic req_s1, req_s2, ack_s1, ack_s2;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              push, pop;

  tx_state_t         tx_state, tx_state_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              req_q, req_nxt;
  logic [TMR_W-1:0]  tmr_q, tmr_nxt;
  logic [1:0]        gap_q, gap_nxt;
  logic [RTY_W-1:0]  rty_q, rty_nxt;
  logic              done_q, done_nxt, err_q, err_nxt;

  rx_state_t         rx_state, rx_state_nxt;
  logic [DATA_W-1:0] rx_data_q, rx_data_nxt;
  logic              rx_valid_q, rx_valid_nxt, ack_q, ack_nxt;

  assign push           = tx_valid && tx_ready;
  assign tx_ready       = (count_q != DEPTH_C);
  assign fifo_count     = count_q;
  assign tx_done        = done_q;
  assign tx_err         = err_q;
  assign rx_valid       = rx_valid_q;
  assign rx_data        = rx_data_q;
  assign Request_out    = req_q;
  assign Ack_out        = ack_q;
  assign inter_data_out = data_q;
  assign link_busy      = (tx_state != IDLE);

  // Two-flop synchronisers for the asynchronous handshake inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      req_s1 <= Request_in;
      req_s2 <= req_s1;
      ack_s1 <= Ack_in;
      ack_s2 <= ack_s1;
    end
  end

  // FIFO storage; emptiness is tracked by the count, so no reset needed here.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // TX FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= IDLE;
      data_q   <= '0;
      req_q    <= 1'b0;
      tmr_q    <= '0;
      gap_q    <= '0;
      rty_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      data_q   <= data_nxt;
      req_q    <= req_nxt;
      tmr_q    <= tmr_nxt;
      gap_q    <= gap_nxt;
      rty_q    <= rty_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
    end
  end

  // TX next-state: the head word is only popped on ack or on the final drop.
  always_comb begin
    tx_state_nxt = tx_state;
    data_nxt     = data_q;
    req_nxt      = req_q;
    tmr_nxt      = tmr_q;
    gap_nxt      = gap_q;
    rty_nxt      = rty_q;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    pop          = 1'b0;
    case (tx_state)
      IDLE: begin
        if (count_q != '0) begin
          data_nxt     = mem[rd_ptr];
          tx_state_nxt = SETUP;
        end
      end
      SETUP: begin
        req_nxt      = 1'b1;
        tmr_nxt      = TMR_LOAD;
        tx_state_nxt = REQ;
      end
      REQ: begin
        if (ack_s2) begin
          req_nxt      = 1'b0;
          pop          = 1'b1;
          done_nxt     = 1'b1;
          rty_nxt      = '0;
          tmr_nxt      = '0;
          tx_state_nxt = REL;
        end else if (tmr_q == '0) begin
          req_nxt      = 1'b0;
          gap_nxt      = 2'd3;
          tx_state_nxt = GAP;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      REL: begin
        if (!ack_s2) tx_state_nxt = IDLE;
      end
      GAP: begin
        if (gap_q != 2'd0) begin
          gap_nxt = gap_q - 1'b1;
        end else if (rty_q < RTY_MAX) begin
          rty_nxt      = rty_q + 1'b1;
          tx_state_nxt = SETUP;
        end else begin
          pop          = 1'b1;
          err_nxt      = 1'b1;
          rty_nxt      = '0;
          tmr_nxt      = '0;
          tx_state_nxt = IDLE;
        end
      end
      default: tx_state_nxt = IDLE;
    endcase
  end

  // RX FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= R_IDLE;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      rx_state   <= rx_state_nxt;
      rx_data_q  <= rx_data_nxt;
      rx_valid_q <= rx_valid_nxt;
      ack_q      <= ack_nxt;
    end
  end

  // RX next-state: capture once per request, hold ack until the request falls.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_data_nxt  = rx_data_q;
    rx_valid_nxt = 1'b0;
    ack_nxt      = ack_q;
    case (rx_state)
      R_IDLE: begin
        if (req_s2) begin
          rx_data_nxt  = inter_data_in;
          rx_valid_nxt = 1'b1;
          ack_nxt      = 1'b1;
          rx_state_nxt = R_ACK;
        end
      end
      R_ACK: begin
        if (!req_s2) begin
          ack_nxt      = 1'b0;
          rx_state_nxt = R_IDLE;
        end
      end
      default: rx_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_interboard_link.sv
// Directed bench for interboard_link with a switchable loopback harness.
module tb_interboard_link;

  localparam int DW = 6;
  localparam int T  = 20;

  logic          clk, rst;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic [2:0]    fifo_count;
  logic          tx_done, tx_err, rx_valid;
  logic [DW-1:0] rx_data;
  logic          Request_out, Ack_out;
  logic [DW-1:0] inter_data_out;
  logic          Request_in, Ack_in;
  logic [DW-1:0] inter_data_in;
  logic          link_busy;

  logic req_loop, ack_loop, req_force, ack_force;

  assign Request_in    = req_loop ? Request_out : req_force;
  assign Ack_in        = ack_loop ? Ack_out : ack_force;
  assign inter_data_in = inter_data_out;

  interboard_link #(.DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT_CYC(T), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .tx_done(tx_done), .tx_err(tx_err),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .Request_out(Request_out), .Ack_out(Ack_out), .inter_data_out(inter_data_out),
    .Request_in(Request_in), .Ack_in(Ack_in), .inter_data_in(inter_data_in),
    .link_busy(link_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event monitor: counts pulses and logs words seen on the link.
  int done_cnt = 0, err_cnt = 0, req_pulses = 0, run_len = 0;
  int width_sum = 0, last_width = 0, stab_err = 0;
  logic req_prev = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic [DW-1:0] rx_log[$];
  logic [DW-1:0] req_data_log[$];

  always @(posedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err)  err_cnt  <= err_cnt + 1;
    if (rx_valid) rx_log.push_back(rx_data);
    if (Request_out) begin
      if (!req_prev) begin
        req_pulses <= req_pulses + 1;
        req_data_log.push_back(inter_data_out);
        held_data <= inter_data_out;
      end else if (inter_data_out !== held_data) begin
        stab_err <= stab_err + 1;
      end
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      last_width <= run_len;
      width_sum  <= width_sum + run_len;
      run_len    <= 0;
    end
    req_prev <= Request_out;
  end

  task automatic push_word(input logic [DW-1:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fifo_count == 3'd0 && !link_busy) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: link not idle, fifo_count=%0d link_busy=%0b, expected 0/0", name, fifo_count, link_busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    req_loop = 1'b0; ack_loop = 1'b0; req_force = 1'b0; ack_force = 1'b0;
    #1;
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++;
    if ({tx_done, tx_err, rx_valid, Request_out, Ack_out, link_busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {tx_done, tx_err, rx_valid, Request_out, Ack_out, link_busy});
    end
    checks++;
    if (rx_data !== 6'h00 || inter_data_out !== 6'h00) begin
      errors++;
      $display("FAIL reset_data: rx_data=%h inter_data_out=%h expected 00/00", rx_data, inter_data_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback;
    int d0 = done_cnt, r0 = rx_log.size();
    bit got = 0;
    req_loop = 1'b1; ack_loop = 1'b1;
    push_word(6'h2A);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin got = 1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL loop_done_wait: no tx_done within 100 cycles"); end
    wait_idle("loop_idle", 50);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_log.size() - r0 != 1) begin errors++; $display("FAIL loop_rx_count: got %0d expected 1", rx_log.size() - r0); end
    checks++;
    if (rx_data !== 6'h2A) begin errors++; $display("FAIL loop_rx_data: got %h expected 2a", rx_data); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL loop_done_count: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (link_busy !== 1'b0) begin errors++; $display("FAIL loop_busy: got %b expected 0", link_busy); end
  endtask

  task automatic test_fifo_full;
    int r0 = rx_log.size(), s0 = stab_err;
    logic [DW-1:0] exp_w [4];
    exp_w[0] = 6'h01; exp_w[1] = 6'h02; exp_w[2] = 6'h03; exp_w[3] = 6'h04;
    req_loop = 1'b1; ack_loop = 1'b0; ack_force = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(DW'(i));
    checks++;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", tx_ready); end
    ack_loop = 1'b1;
    wait_idle("full_drain", 300);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_log.size() - r0 != 4) begin errors++; $display("FAIL full_rx_count: got %0d expected 4", rx_log.size() - r0); end
    for (int i = 0; i < 4; i++) begin
      if (r0 + i < rx_log.size()) begin
        checks++;
        if (rx_log[r0 + i] !== exp_w[i]) begin
          errors++;
          $display("FAIL full_order[%0d]: got %h expected %h", i, rx_log[r0 + i], exp_w[i]);
        end
      end
    end
    checks++;
    if (stab_err != s0) begin errors++; $display("FAIL full_data_stable: %0d changes, expected 0", stab_err - s0); end
  endtask

  task automatic test_timeout;
    int e0 = err_cnt, p0 = req_pulses, w0 = width_sum, d0 = done_cnt;
    bit got = 0;
    req_loop = 1'b0; ack_loop = 1'b0; req_force = 1'b0; ack_force = 1'b0;
    push_word(6'h15);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err_cnt != e0) begin got = 1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL timeout_err_wait: no tx_err within 400 cycles"); end
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL timeout_count: got %0d expected 0", fifo_count); end
    repeat (10) @(negedge clk);
    checks++;
    if (req_pulses - p0 != 4) begin errors++; $display("FAIL timeout_pulses: got %0d expected 4", req_pulses - p0); end
    checks++;
    if (width_sum - w0 != 4 * T || last_width != T) begin
      errors++;
      $display("FAIL timeout_width: total %0d last %0d expected %0d/%0d", width_sum - w0, last_width, 4 * T, T);
    end
    checks++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      errors++;
      $display("FAIL timeout_pulse_counts: err %0d done %0d expected 1/0", err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (link_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", link_busy); end
  endtask

  task automatic test_retry_success;
    int e0 = err_cnt, d0 = done_cnt, p0 = req_pulses, s0 = stab_err;
    bit fell = 0;
    req_loop = 1'b0; ack_loop = 1'b0; req_force = 1'b0; ack_force = 1'b0;
    push_word(6'h39);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_pulses - p0 == 1 && !Request_out) begin fell = 1; break; end
    end
    checks++;
    if (!fell) begin errors++; $display("FAIL retry_first_timeout: first attempt did not time out"); end
    req_loop = 1'b1; ack_loop = 1'b1;
    wait_idle("retry_idle", 200);
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      errors++;
      $display("FAIL retry_counts: done %0d err %0d expected 1/0", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (req_pulses - p0 != 2) begin errors++; $display("FAIL retry_attempts: got %0d expected 2", req_pulses - p0); end
    if (req_data_log.size() >= p0 + 2) begin
      checks++;
      if (req_data_log[p0] !== 6'h39 || req_data_log[p0 + 1] !== 6'h39) begin
        errors++;
        $display("FAIL retry_data: got %h/%h expected 39/39", req_data_log[p0], req_data_log[p0 + 1]);
      end
    end
    checks++;
    if (stab_err != s0) begin errors++; $display("FAIL retry_data_stable: %0d changes, expected 0", stab_err - s0); end
  endtask

  task automatic test_push_pop_same_cycle;
    int r0;
    bit up = 0;
    req_loop = 1'b0; ack_loop = 1'b0; req_force = 1'b0; ack_force = 1'b0;
    push_word(6'h0A);
    push_word(6'h0B);
    checks++;
    if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_pre_count: got %0d expected 2", fifo_count); end
    for (int i = 0; i < 20; i++) begin
      if (Request_out) begin up = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!up) begin errors++; $display("FAIL pp_req_wait: Request_out never rose"); end
    r0 = rx_log.size();
    ack_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 6'h33;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (tx_done !== 1'b1) begin errors++; $display("FAIL pp_pop_cycle: tx_done=%b expected 1", tx_done); end
    checks++;
    if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_count: got %0d expected 2", fifo_count); end
    req_loop = 1'b1; ack_loop = 1'b1;
    wait_idle("pp_drain", 200);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_log.size() - r0 != 2) begin
      errors++;
      $display("FAIL pp_rx_count: got %0d expected 2", rx_log.size() - r0);
    end else begin
      checks++;
      if (rx_log[r0] !== 6'h0B || rx_log[r0 + 1] !== 6'h33) begin
        errors++;
        $display("FAIL pp_rx_order: got %h/%h expected 0b/33", rx_log[r0], rx_log[r0 + 1]);
      end
    end
  endtask

  task automatic test_reset_mid_req;
    int d0, e0;
    bit up = 0;
    req_loop = 1'b0; ack_loop = 1'b0; req_force = 1'b0; ack_force = 1'b0;
    push_word(6'h11);
    push_word(6'h12);
    push_word(6'h13);
    for (int i = 0; i < 20; i++) begin
      if (Request_out) begin up = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!up) begin errors++; $display("FAIL rstreq_wait: Request_out never rose"); end
    checks++;
    if (fifo_count !== 3'd3) begin errors++; $display("FAIL rstreq_pre_count: got %0d expected 3", fifo_count); end
    d0 = done_cnt; e0 = err_cnt;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (Request_out !== 1'b0) begin errors++; $display("FAIL rstreq_request: got %b expected 0", Request_out); end
    checks++;
    if (fifo_count !== 3'd0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstreq_fifo: count %0d ready %b expected 0/1", fifo_count, tx_ready);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0 || err_cnt != e0 || link_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstreq_no_pulse: done %0d err %0d busy %b expected 0/0/0", done_cnt - d0, err_cnt - e0, link_busy);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_fifo_full();
    test_timeout();
    test_retry_success();
    test_push_pop_same_cycle();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
